// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          IRAM_AWIDTH      = 12;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched {instr, pc} pairs; flush empties it and wins over push.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t r_mem [0:1];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // The issue throttle guarantees a full buffer never receives a write.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !flush && r_count == 2'd2));
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, one-deep RAM pipeline and a 2-entry output buffer.
// Handshake: a word transfers to decode on a rising edge where instr_valid && instr_ready;
// while instr_valid=1 and instr_ready=0 the head (instr, instr_pc) is held unchanged.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IRAM_AWIDTH-1:0] ram_addr,
  input  logic [31:0]            ram_dout,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            instr,
  output logic [31:0]            instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready
);
  logic [31:0]  r_pc;
  logic         r_inflight;
  logic         w_pop;
  logic         w_issue;
  logic         w_push;
  logic [2:0]   w_occ;
  logic [1:0]   w_count;
  logic [31:0]  w_target;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;

  always_comb begin
    w_pop    = instr_valid && instr_ready;
    // Occupancy after this edge if nothing new is issued; the in-flight word needs a slot.
    w_occ    = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    w_issue  = !redirect && (w_occ < 3'(FIFO_DEPTH));
    w_push   = r_inflight && !redirect;
    w_target = redirect_pc & ~32'h3;
    w_entry  = '{instr: ram_dout, pc: r_pc - 32'd4};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (redirect) begin
      r_pc       <= w_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_pc <= r_pc + 32'd4;
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_entry),
    .pop       (w_pop),
    .flush     (redirect),
    .count     (w_count),
    .head      (w_head)
  );

  assign ram_addr    = r_pc[IRAM_AWIDTH+1:2];
  assign instr_valid = (w_count != 2'd0);
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
endmodule
